rom_port_arbiter: RTL and testbench

- Shares the single synchronous program ROM read port (8-bit address, registered 8-bit data, 1-cycle read latency) between two requesters.
- Port A is the CPU instruction fetch and has default priority.
- Port B is a secondary reader, e.g. a debug/checksum engine.
- The block sits between both requesters and the ROM. It grants one read per cycle, routes the returned byte to the requester that issued it, and prevents starvation of port B.

---
 rtl/rom_port_arbiter_pkg.sv | 22 ++
 rtl/rom_return_router.sv | 50 +++++
 rtl/rom_port_arbiter.sv | 126 ++++++++++++
 tb/tb_rom_port_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_port_arbiter_pkg.sv
// rtl/rom_port_arbiter_pkg.sv - shared encodings and default widths for the ROM port arbiter
//
// Purpose: in-flight tag encoding, arbiter FSM state type and default
// parameter values shared by rom_port_arbiter and rom_return_router.
package rom_port_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH  = 8;
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_MAX_WAIT    = 4;
  localparam int DEF_B_BURST_MAX = 8;

  // Identifies which requester owns the read currently inside the ROM.
  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_A    = 2'd1;
  localparam logic [1:0] TAG_B    = 2'd2;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rom_return_router.sv
// rtl/rom_return_router.sv - steers the ROM read data back to the requester that issued it
//
// Purpose: tracks the owner of the read in flight and captures the ROM byte
// into that owner's data register one cycle after the ROM registers it.
// Ports:
//   CLK, RESET_N      clock, asynchronous active-low reset
//   issue_tag         owner of the read granted this cycle (TAG_NONE/A/B)
//   rom_data          ROM registered data output
//   a_rvalid/a_rdata  returned byte for port A, valid for one cycle
//   b_rvalid/b_rdata  returned byte for port B, valid for one cycle
module rom_return_router
  import rom_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [1:0]            issue_tag,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata
);

  // tag_q travels alongside the ROM's own address register, so during the
  // cycle it is valid rom_data belongs to the owner it names.
  logic [1:0] tag_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tag_q    <= TAG_NONE;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      tag_q    <= issue_tag;
      a_rvalid <= (tag_q == TAG_A);
      b_rvalid <= (tag_q == TAG_B);
      if (tag_q == TAG_A) begin
        a_rdata <= rom_data;
      end
      if (tag_q == TAG_B) begin
        b_rdata <= rom_data;
      end
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - two-port arbiter in front of a single synchronous program ROM
//
// Purpose: grants one ROM read per cycle to port A (CPU fetch, default
// priority) or port B (secondary reader), bounds B's starvation with a wait
// counter, supports bounded B bursts under B_LOCK, and routes read data back.
// Ports:
//   CLK, RESET_N                 clock, asynchronous active-low reset
//   A_REQ, A_ADDR, A_GNT         port A request / address / combinational grant
//   A_RVALID, A_RDATA            port A returned byte, 2 cycles after grant
//   B_REQ, B_ADDR, B_LOCK, B_GNT port B request / address / burst lock / grant
//   B_RVALID, B_RDATA            port B returned byte, 2 cycles after grant
//   ROM_ADDR, ROM_DATA           ROM address (combinational) and registered data
module rom_port_arbiter
  import rom_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int MAX_WAIT    = DEF_MAX_WAIT,
  parameter int B_BURST_MAX = DEF_B_BURST_MAX
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  A_REQ,
  input  logic [ADDR_WIDTH-1:0] A_ADDR,
  output logic                  A_GNT,
  output logic                  A_RVALID,
  output logic [DATA_WIDTH-1:0] A_RDATA,
  input  logic                  B_REQ,
  input  logic [ADDR_WIDTH-1:0] B_ADDR,
  input  logic                  B_LOCK,
  output logic                  B_GNT,
  output logic                  B_RVALID,
  output logic [DATA_WIDTH-1:0] B_RDATA,
  output logic [ADDR_WIDTH-1:0] ROM_ADDR,
  input  logic [DATA_WIDTH-1:0] ROM_DATA
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(B_BURST_MAX + 1);
  localparam logic [WW-1:0] WAIT_LIMIT  = WW'(MAX_WAIT);
  localparam logic [BW-1:0] BURST_LIMIT = BW'(B_BURST_MAX);

  arb_state_t            state;
  logic [WW-1:0]         wait_cnt;
  logic [BW-1:0]         burst_cnt;
  logic [ADDR_WIDTH-1:0] last_addr;

  logic       b_force;
  logic       b_cont;
  logic       a_win;
  logic       b_win;
  logic [1:0] issue_tag;

  // b_cont: B keeps its burst this cycle. When it does not, the cycle is
  // arbitrated exactly as in ST_ARB, which also covers the burst exit cycle.
  always_comb begin
    b_force = B_REQ && (wait_cnt == WAIT_LIMIT);
    b_cont  = (state == ST_BURST) && B_REQ && B_LOCK && (burst_cnt < BURST_LIMIT);
    a_win   = !b_cont && A_REQ && !b_force;
    b_win   = b_cont || (!a_win && B_REQ);

    issue_tag = TAG_NONE;
    if (a_win) begin
      issue_tag = TAG_A;
    end else if (b_win) begin
      issue_tag = TAG_B;
    end

    // Idle cycles keep the previous address on the ROM bus.
    ROM_ADDR = last_addr;
    if (a_win) begin
      ROM_ADDR = A_ADDR;
    end else if (b_win) begin
      ROM_ADDR = B_ADDR;
    end
  end

  assign A_GNT = a_win;
  assign B_GNT = b_win;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_ARB;
      wait_cnt  <= '0;
      burst_cnt <= '0;
      last_addr <= '0;
    end else begin
      if (a_win) begin
        last_addr <= A_ADDR;
      end else if (b_win) begin
        last_addr <= B_ADDR;
      end

      if (!B_REQ || b_win) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_LIMIT) begin
        wait_cnt <= wait_cnt + WW'(1);
      end

      if (b_cont) begin
        burst_cnt <= burst_cnt + BW'(1);
      end else if (b_win && B_LOCK) begin
        // Entering (or re-entering) a burst: this grant is the first slot.
        state     <= ST_BURST;
        burst_cnt <= BW'(1);
      end else begin
        state     <= ST_ARB;
        burst_cnt <= '0;
      end
    end
  end

  rom_return_router #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_router (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .issue_tag(issue_tag),
    .rom_data (ROM_DATA),
    .a_rvalid (A_RVALID),
    .a_rdata  (A_RDATA),
    .b_rvalid (B_RVALID),
    .b_rdata  (B_RDATA)
  );

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb/tb_rom_port_arbiter.sv - self-checking bench for rom_port_arbiter
module tb_rom_port_arbiter;

  localparam logic [1:0] TB_NONE = 2'd0;
  localparam logic [1:0] TB_A    = 2'd1;
  localparam logic [1:0] TB_B    = 2'd2;

  logic       CLK;
  logic       RESET_N;
  logic       A_REQ;
  logic [7:0] A_ADDR;
  logic       A_GNT;
  logic       A_RVALID;
  logic [7:0] A_RDATA;
  logic       B_REQ;
  logic [7:0] B_ADDR;
  logic       B_LOCK;
  logic       B_GNT;
  logic       B_RVALID;
  logic [7:0] B_RDATA;
  logic [7:0] ROM_ADDR;
  logic [7:0] ROM_DATA;

  logic [7:0] rom_mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] h1_tag, h2_tag;
  logic [7:0] h1_addr, h2_addr;

  typedef struct {
    logic       a_req;
    logic [7:0] a_addr;
    logic       b_req;
    logic [7:0] b_addr;
    logic       a_gnt;
    logic       b_gnt;
    logic [7:0] rom_addr;
    logic       a_rv;
    logic [7:0] a_rd;
    logic       b_rv;
    logic [7:0] b_rd;
  } vec_t;

  vec_t vecs [20];

  rom_port_arbiter dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .A_REQ   (A_REQ),
    .A_ADDR  (A_ADDR),
    .A_GNT   (A_GNT),
    .A_RVALID(A_RVALID),
    .A_RDATA (A_RDATA),
    .B_REQ   (B_REQ),
    .B_ADDR  (B_ADDR),
    .B_LOCK  (B_LOCK),
    .B_GNT   (B_GNT),
    .B_RVALID(B_RVALID),
    .B_RDATA (B_RDATA),
    .ROM_ADDR(ROM_ADDR),
    .ROM_DATA(ROM_DATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous ROM model, one-cycle registered read.
  always @(posedge CLK) ROM_DATA <= rom_mem[ROM_ADDR];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs mid-cycle; outputs are sampled 1 time unit later.
  task automatic drive(input logic ar, input logic [7:0] aa, input logic br,
                       input logic [7:0] ba, input logic bl);
    @(negedge CLK);
    A_REQ  = ar;
    A_ADDR = aa;
    B_REQ  = br;
    B_ADDR = ba;
    B_LOCK = bl;
    #1;
  endtask

  // Checks this cycle's grant and the return owed from two cycles earlier.
  task automatic expect_cycle(input logic [1:0] tag, input logic [7:0] addr);
    chk("a_gnt", 8'(A_GNT), 8'(tag == TB_A));
    chk("b_gnt", 8'(B_GNT), 8'(tag == TB_B));
    if (tag != TB_NONE) chk("rom_addr", ROM_ADDR, addr);
    chk("a_rvalid", 8'(A_RVALID), 8'(h2_tag == TB_A));
    chk("b_rvalid", 8'(B_RVALID), 8'(h2_tag == TB_B));
    if (h2_tag == TB_A) chk("a_rdata", A_RDATA, h2_addr ^ 8'hA5);
    if (h2_tag == TB_B) chk("b_rdata", B_RDATA, h2_addr ^ 8'hA5);
    h2_tag  = h1_tag;
    h2_addr = h1_addr;
    h1_tag  = tag;
    h1_addr = addr;
  endtask

  task automatic clear_hist();
    h1_tag  = TB_NONE;
    h2_tag  = TB_NONE;
    h1_addr = 8'h00;
    h2_addr = 8'h00;
  endtask

  task automatic drain2();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    expect_cycle(TB_NONE, 8'h00);
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    expect_cycle(TB_NONE, 8'h00);
  endtask

  initial begin
    logic [7:0] na, nb;
    logic       lock;
    logic       want_b;

    for (int k = 0; k < 256; k++) rom_mem[k] = 8'(k) ^ 8'hA5;

    //          a_req a_addr b_req b_addr a_gnt b_gnt rom   a_rv a_rd  b_rv b_rd
    vecs[0]  = '{1'b1, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h10, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h10, 1'b1, 8'hB5, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h10, 1'b0, 8'hB5, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 8'h20, 1'b0, 1'b1, 8'h20, 1'b0, 8'hB5, 1'b0, 8'h00};
    vecs[5]  = '{1'b1, 8'h30, 1'b1, 8'h21, 1'b1, 1'b0, 8'h30, 1'b0, 8'hB5, 1'b0, 8'h00};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h30, 1'b0, 8'hB5, 1'b1, 8'h85};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h30, 1'b1, 8'h95, 1'b0, 8'h85};
    vecs[8]  = '{1'b1, 8'h40, 1'b1, 8'h22, 1'b1, 1'b0, 8'h40, 1'b0, 8'h95, 1'b0, 8'h85};
    vecs[9]  = '{1'b1, 8'h41, 1'b1, 8'h22, 1'b1, 1'b0, 8'h41, 1'b0, 8'h95, 1'b0, 8'h85};
    vecs[10] = '{1'b1, 8'h42, 1'b0, 8'h00, 1'b1, 1'b0, 8'h42, 1'b1, 8'hE5, 1'b0, 8'h85};
    vecs[11] = '{1'b1, 8'h43, 1'b0, 8'h00, 1'b1, 1'b0, 8'h43, 1'b1, 8'hE4, 1'b0, 8'h85};
    vecs[12] = '{1'b1, 8'h44, 1'b1, 8'h23, 1'b1, 1'b0, 8'h44, 1'b1, 8'hE7, 1'b0, 8'h85};
    vecs[13] = '{1'b1, 8'h45, 1'b1, 8'h23, 1'b1, 1'b0, 8'h45, 1'b1, 8'hE6, 1'b0, 8'h85};
    vecs[14] = '{1'b1, 8'h46, 1'b1, 8'h23, 1'b1, 1'b0, 8'h46, 1'b1, 8'hE1, 1'b0, 8'h85};
    vecs[15] = '{1'b1, 8'h47, 1'b1, 8'h23, 1'b1, 1'b0, 8'h47, 1'b1, 8'hE0, 1'b0, 8'h85};
    vecs[16] = '{1'b1, 8'h48, 1'b1, 8'h23, 1'b0, 1'b1, 8'h23, 1'b1, 8'hE3, 1'b0, 8'h85};
    vecs[17] = '{1'b1, 8'h48, 1'b0, 8'h00, 1'b1, 1'b0, 8'h48, 1'b1, 8'hE2, 1'b0, 8'h85};
    vecs[18] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h48, 1'b0, 8'hE2, 1'b1, 8'h86};
    vecs[19] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h48, 1'b1, 8'hED, 1'b0, 8'h86};

    clear_hist();
    RESET_N = 1'b0;
    A_REQ = 1'b0; A_ADDR = 8'h00;
    B_REQ = 1'b0; B_ADDR = 8'h00; B_LOCK = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk("rst_a_rvalid", 8'(A_RVALID), 8'h00);
    chk("rst_b_rvalid", 8'(B_RVALID), 8'h00);
    chk("rst_a_rdata", A_RDATA, 8'h00);
    chk("rst_b_rdata", B_RDATA, 8'h00);
    chk("rst_rom_addr", ROM_ADDR, 8'h00);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Directed table: single fetch, B-only, simultaneous, B pulse drop, forced B.
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].a_req, vecs[i].a_addr, vecs[i].b_req, vecs[i].b_addr, 1'b0);
      chk($sformatf("v%0d_a_gnt", i), 8'(A_GNT), 8'(vecs[i].a_gnt));
      chk($sformatf("v%0d_b_gnt", i), 8'(B_GNT), 8'(vecs[i].b_gnt));
      chk($sformatf("v%0d_rom_addr", i), ROM_ADDR, vecs[i].rom_addr);
      chk($sformatf("v%0d_a_rvalid", i), 8'(A_RVALID), 8'(vecs[i].a_rv));
      chk($sformatf("v%0d_a_rdata", i), A_RDATA, vecs[i].a_rd);
      chk($sformatf("v%0d_b_rvalid", i), 8'(B_RVALID), 8'(vecs[i].b_rv));
      chk($sformatf("v%0d_b_rdata", i), B_RDATA, vecs[i].b_rd);
    end

    // Back-to-back A fetches 0..5.
    clear_hist();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 8'(k), 1'b0, 8'h00, 1'b0);
      expect_cycle(TB_A, 8'(k));
    end
    drain2();

    // A and B held: A,A,A,A,B repeating.
    na = 8'h00;
    nb = 8'h00;
    for (int c = 0; c < 15; c++) begin
      drive(1'b1, 8'h60 + na, 1'b1, 8'h80 + nb, 1'b0);
      if ((c % 5) == 4) begin
        expect_cycle(TB_B, 8'h80 + nb);
        nb = nb + 8'h01;
      end else begin
        expect_cycle(TB_A, 8'h60 + na);
        na = na + 8'h01;
      end
    end
    drain2();

    // B_LOCK burst: 4 A, 8 B, 4 A, B re-enters burst, lock drop hands back to A.
    na = 8'h00;
    nb = 8'h00;
    for (int c = 0; c < 19; c++) begin
      lock   = (c < 18);
      want_b = ((c >= 4) && (c < 12)) || (c == 16) || (c == 17);
      drive(1'b1, 8'hC0 + na, 1'b1, 8'hD0 + nb, lock);
      if (want_b) begin
        expect_cycle(TB_B, 8'hD0 + nb);
        nb = nb + 8'h01;
      end else begin
        expect_cycle(TB_A, 8'hC0 + na);
        na = na + 8'h01;
      end
    end
    drain2();

    // Reset one cycle after a B grant: the read is dropped.
    drive(1'b0, 8'h00, 1'b1, 8'h90, 1'b0);
    expect_cycle(TB_B, 8'h90);
    @(negedge CLK);
    B_REQ   = 1'b0;
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_a_rvalid", 8'(A_RVALID), 8'h00);
    chk("mid_rst_b_rvalid", 8'(B_RVALID), 8'h00);
    chk("mid_rst_a_rdata", A_RDATA, 8'h00);
    chk("mid_rst_b_rdata", B_RDATA, 8'h00);
    chk("mid_rst_rom_addr", ROM_ADDR, 8'h00);
    chk("mid_rst_b_gnt", 8'(B_GNT), 8'h00);
    @(negedge CLK);
    RESET_N = 1'b1;
    clear_hist();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      expect_cycle(TB_NONE, 8'h00);
    end
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 8'hF0 + 8'(c), 1'b1, 8'h9A, 1'b0);
      if (c == 4) expect_cycle(TB_B, 8'h9A);
      else expect_cycle(TB_A, 8'hF0 + 8'(c));
    end
    drain2();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
